// File: rtl/seq_generator.sv
// seq_generator: serial bit-pattern transmitter.
// Latches a pattern of programmable length and shifts it out MSB-first, one
// bit per clock, repeating it reps+1 times with GAP_LEN idle cycles between
// repetitions. Optional even-parity bit per repetition when SEQ_GEN_PARITY_EN
// is defined.
// Ports:
//   clk        - clock, all logic on posedge
//   rst        - asynchronous active-low reset
//   start      - transmit request, sampled only in IDLE
//   pattern    - bits to send, bit len-1 goes first
//   len        - number of pattern bits, 1..MAX_LEN
//   reps       - extra repetitions (total = reps+1)
//   dout       - serial data bit
//   dout_valid - dout carries a pattern/parity bit
//   busy       - frame in progress (first bit cycle through DONE)
//   done       - one-cycle pulse after the final bit
module seq_generator #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned REP_W   = 4,
  parameter int unsigned GAP_LEN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   reps,
  output logic               dout,
  output logic               dout_valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;    // latched pattern, MSB-aligned
  logic [MAX_LEN-1:0] shreg;    // bits still to send, next bit at MSB
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   bit_cnt;  // pattern bits remaining after the one on dout
  logic [REP_W-1:0]   rep_cnt;
  logic [GAP_W-1:0]   gap_cnt;
`ifdef SEQ_GEN_PARITY_EN
  logic               par_sent;
`endif

  logic               len_ok_c;
  logic [MAX_LEN-1:0] aligned_c;

  // Left-align the pattern so bit len-1 sits at the MSB and zeros fill below;
  // XOR over the aligned word is then the parity of the transmitted bits.
  assign len_ok_c  = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign aligned_c = pattern << (LEN_W'(MAX_LEN) - len);

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pat_q      <= '0;
      shreg      <= '0;
      len_q      <= '0;
      bit_cnt    <= '0;
      rep_cnt    <= '0;
      gap_cnt    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_sent   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && len_ok_c) begin
            pat_q      <= aligned_c;
            shreg      <= aligned_c << 1;
            len_q      <= len;
            bit_cnt    <= len - 1'b1;
            rep_cnt    <= reps;
            dout       <= aligned_c[MAX_LEN-1];
            dout_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
`ifdef SEQ_GEN_PARITY_EN
            par_sent   <= 1'b0;
`endif
          end
        end

        SEND: begin
          if (bit_cnt != '0) begin
            dout    <= shreg[MAX_LEN-1];
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - 1'b1;
          end
`ifdef SEQ_GEN_PARITY_EN
          else if (!par_sent) begin
            dout     <= ^pat_q;
            par_sent <= 1'b1;
          end
`endif
          else if (rep_cnt != '0) begin
            rep_cnt <= rep_cnt - 1'b1;
            if (GAP_LEN == 0) begin
              // Back-to-back: restart the pattern directly.
              dout     <= pat_q[MAX_LEN-1];
              shreg    <= pat_q << 1;
              bit_cnt  <= len_q - 1'b1;
`ifdef SEQ_GEN_PARITY_EN
              par_sent <= 1'b0;
`endif
            end else begin
              dout       <= 1'b0;
              dout_valid <= 1'b0;
              gap_cnt    <= GAP_W'(GAP_LEN - 1);
              state      <= GAP;
            end
          end else begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end

        GAP: begin
          if (gap_cnt == '0) begin
            dout       <= pat_q[MAX_LEN-1];
            shreg      <= pat_q << 1;
            bit_cnt    <= len_q - 1'b1;
            dout_valid <= 1'b1;
            state      <= SEND;
`ifdef SEQ_GEN_PARITY_EN
            par_sent   <= 1'b0;
`endif
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// tb_seq_generator: self-checking bench for seq_generator.
// A frame model expands each accepted request into the expected per-cycle
// {dout, dout_valid, busy, done} sequence; every cycle is compared against it,
// alongside hand-computed literal expectations for the directed scenarios.
module tb_seq_generator;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned REP_W   = 4;
  localparam int unsigned GAP_LEN = 2;

  logic               clk;
  logic               rst;
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [REP_W-1:0]   reps;
  logic               dout;
  logic               dout_valid;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  seq_generator #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .REP_W  (REP_W),
    .GAP_LEN(GAP_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .reps      (reps),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle tuples {dout, dout_valid, busy, done}.
  logic [3:0] exp_q[$];
  bit         cur_idle = 1'b1;
  bit         cmp_en   = 1'b0;

  // Expand one accepted request into its full expected frame.
  task automatic build_frame(input logic [7:0] p, input int n, input int r);
    logic [7:0] w;
    logic       par;
    for (int k = 0; k <= r; k++) begin
      w   = p << (8 - n);
      par = 1'b0;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({w[7], 3'b110});
        par = par ^ w[7];
        w   = w << 1;
      end
`ifdef SEQ_GEN_PARITY_EN
      exp_q.push_back({par, 3'b110});
`endif
      if (k < r)
        for (int g = 0; g < int'(GAP_LEN); g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
  endtask

  // Model acceptance: only from a cycle in which nothing was in flight.
  always @(posedge clk) begin
    if (rst && cur_idle && start && len != 0 && int'(len) <= int'(MAX_LEN))
      build_frame(pattern, int'(len), int'(reps));
  end

  // Reset aborts any frame immediately.
  always @(negedge rst) exp_q.delete();

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] e;
    logic [3:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cur_idle = 1'b0;
    end else begin
      e = 4'b0000;
      cur_idle = 1'b1;
    end
    if (cmp_en) begin
      a = {dout, dout_valid, busy, done};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t actual={dout,valid,busy,done}=%b required=%b", $time, a, e);
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int outs();
    return int'({dout, dout_valid, busy, done});
  endfunction

  // One-cycle start pulse; inputs are scrambled afterwards to prove they are latched.
  task automatic pulse_start(input logic [7:0] p, input logic [3:0] n, input logic [3:0] r);
    @(negedge clk);
    start   = 1'b1;
    pattern = p;
    len     = n;
    reps    = r;
    @(negedge clk);
    start   = 1'b0;
    pattern = ~p;
    len     = 4'd7;
    reps    = 4'd3;
  endtask

  task automatic count(input int n, output int nb, output int nv, output int nd);
    nb = 0; nv = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      nb += int'(busy);
      nv += int'(dout_valid);
      nd += int'(done);
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, nv, nd;
    rst = 1'b0; start = 1'b0; pattern = '0; len = '0; reps = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame 101, len 3, no repeats.
    pulse_start(8'b0000_0101, 4'd3, 4'd0);
    chk("t1_cycle1", outs(), 4'b1110);
    @(negedge clk); chk("t1_cycle2", outs(), 4'b0110);
    @(negedge clk); chk("t1_cycle3", outs(), 4'b1110);
`ifdef SEQ_GEN_PARITY_EN
    @(negedge clk); chk("t1_parity", outs(), 4'b0110);
`endif
    @(negedge clk); chk("t1_done", outs(), 4'b0011);
    @(negedge clk); chk("t1_idle", outs(), 4'b0000);
    repeat (3) @(negedge clk);

    // One repeat with gap.
    pulse_start(8'b0000_0101, 4'd3, 4'd1);
    count(20, nb, nv, nd);
`ifdef SEQ_GEN_PARITY_EN
    chk("t2_busy_cycles", nb, 11);
    chk("t2_valid_cycles", nv, 8);
`else
    chk("t2_busy_cycles", nb, 9);
    chk("t2_valid_cycles", nv, 6);
`endif
    chk("t2_done_pulses", nd, 1);

    // Illegal lengths are ignored.
    pulse_start(8'hFF, 4'd0, 4'd0);
    count(5, nb, nv, nd);
    chk("t3_len0_busy", nb + nv + nd, 0);
    pulse_start(8'hFF, 4'd9, 4'd0);
    count(5, nb, nv, nd);
    chk("t3_len9_busy", nb + nv + nd, 0);

    // start mid-frame does not disturb the frame in flight.
    pulse_start(8'hF0, 4'd8, 4'd0);
    @(negedge clk);
    start = 1'b1; pattern = 8'h0F; len = 4'd4;
    @(negedge clk);
    start = 1'b0;
    count(20, nb, nv, nd);
    chk("t4_done_pulses", nd, 1);
    repeat (3) @(negedge clk);

    // Asynchronous reset during the second bit.
    pulse_start(8'hA5, 4'd8, 4'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("t5_async_reset", outs(), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    count(6, nb, nv, nd);
    chk("t5_stays_idle", nb + nv + nd, 0);

    // Maximum repeat count: 16 transmissions of a single 1.
    pulse_start(8'h01, 4'd1, 4'd15);
    count(70, nb, nv, nd);
`ifdef SEQ_GEN_PARITY_EN
    chk("t6_valid_cycles", nv, 32);
`else
    chk("t6_valid_cycles", nv, 16);
`endif
    chk("t6_done_pulses", nd, 1);

    // start held high: re-accepted only after DONE.
    @(negedge clk);
    start = 1'b1; pattern = 8'b10; len = 4'd2; reps = 4'd0;
    repeat (8) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

`ifdef SEQ_GEN_PARITY_EN
    // Parity of 111 is 1.
    pulse_start(8'b0000_0111, 4'd3, 4'd0);
    chk("t8_bit1", outs(), 4'b1110);
    @(negedge clk); chk("t8_bit2", outs(), 4'b1110);
    @(negedge clk); chk("t8_bit3", outs(), 4'b1110);
    @(negedge clk); chk("t8_parity", outs(), 4'b1110);
    @(negedge clk); chk("t8_done", outs(), 4'b0011);
    repeat (3) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
